// File: rtl/pwm_duty_ramp_if.sv
// Target-duty command channel between a motor controller and pwm_duty_ramp.
// The master offers tgt_duty with tgt_valid; the ramp block answers with tgt_ready.
interface pwm_duty_ramp_if #(
   parameter int unsigned WIDTH = 10
) ();

   logic [WIDTH-1:0] tgt_duty;
   logic             tgt_valid;
   logic             tgt_ready;

   modport master (
      output tgt_duty,
      output tgt_valid,
      input  tgt_ready
   );

   modport slave (
      input  tgt_duty,
      input  tgt_valid,
      output tgt_ready
   );

endinterface

// File: rtl/pwm_duty_ramp.sv
// Slew-rate-limited duty controller for one pwm_gen channel: walks duty toward the
// accepted target by at most step counts per PWM period, with immediate emergency stop.
module pwm_duty_ramp #(
   parameter int unsigned WIDTH = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             period_end_i,
   input  logic [WIDTH-1:0] step_i,
   input  logic             estop_i,
   pwm_duty_ramp_if.slave   tgt_if,
   output logic [WIDTH-1:0] duty_o,
   output logic             busy_o,
   output logic             at_target_o
);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRamp = 2'd1,
      StStop = 2'd2
   } state_e;

   state_e           state_q;
   logic [WIDTH-1:0] tgt_q;
   logic [WIDTH-1:0] duty_q;
   logic             busy_q;
   logic             at_target_q;
   logic             ready_q;

   logic             accept;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] mag;
   logic             land;

   // diff[WIDTH] set means the target lies below the current duty.
   always_comb begin
      accept = tgt_if.tgt_valid & ready_q;
      diff   = {1'b0, tgt_q} - {1'b0, duty_q};
      mag    = diff[WIDTH] ? (duty_q - tgt_q) : (tgt_q - duty_q);
      land   = (step_i == '0) || (mag <= step_i);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         tgt_q       <= '0;
         duty_q      <= '0;
         busy_q      <= 1'b0;
         at_target_q <= 1'b0;
         ready_q     <= 1'b0;
      end else if (estop_i) begin
         state_q     <= StStop;
         tgt_q       <= '0;
         duty_q      <= '0;
         busy_q      <= 1'b0;
         at_target_q <= 1'b0;
         ready_q     <= 1'b0;
      end else begin
         at_target_q <= 1'b0;
         ready_q     <= 1'b1;
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  tgt_q <= tgt_if.tgt_duty;
                  if (tgt_if.tgt_duty != duty_q) begin
                     state_q <= StRamp;
                     busy_q  <= 1'b1;
                  end
               end else if (tgt_q != duty_q) begin
                  // A retarget that landed together with a ramp completion.
                  state_q <= StRamp;
                  busy_q  <= 1'b1;
               end
            end
            StRamp: begin
               if (accept) begin
                  tgt_q <= tgt_if.tgt_duty;
               end
               if (period_end_i) begin
                  if (land) begin
                     duty_q      <= tgt_q;
                     state_q     <= StIdle;
                     busy_q      <= 1'b0;
                     at_target_q <= 1'b1;
                  end else if (diff[WIDTH]) begin
                     duty_q <= duty_q - step_i;
                  end else begin
                     duty_q <= duty_q + step_i;
                  end
               end
            end
            StStop: begin
               state_q <= StIdle;
               duty_q  <= '0;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign duty_o           = duty_q;
   assign busy_o           = busy_q;
   assign at_target_o      = at_target_q;
   assign tgt_if.tgt_ready = ready_q;

endmodule

// File: doc/pwm_duty_ramp.md
# pwm_duty_ramp

Slew-rate-limited duty controller for one `pwm_gen` channel (one instance per drive motor). It accepts target duty commands through a valid/ready handshake and walks the commanded duty toward the target by at most `step` counts per PWM period. It changes `duty` only on PWM period boundaries, so every PWM period sees one stable duty value. An emergency-stop input overrides ramping and forces duty to zero immediately.

## Interface
- `WIDTH`, default 10: duty width; must equal the `pwm_gen` duty/counter width.
- `clk  in  1`: sole clock, shared with `pwm_gen`.
- `rst  in  1`: synchronous, active-high reset.
- `period_end  in  1`: one-cycle pulse on the cycle the `pwm_gen` counter equals all-ones (last cycle of the period).
- `tgt_duty  in  WIDTH`: requested duty.
- `tgt_valid  in  1`: `tgt_duty` is valid.
- `tgt_ready  out  1`: a target can be accepted. Acceptance occurs when `tgt_valid & tgt_ready` at a rising edge.
- `step  in  WIDTH`: maximum duty change per period. 0 means jump straight to the target.
- `estop  in  1`: level emergency stop.
- `duty  out  WIDTH`: registered duty output, drives `pwm_gen` duty.
- `busy  out  1`: high while in RAMP.
- `at_target  out  1`: one-cycle pulse when a ramp completes.

## Operation
- The block holds a target register `tgt`. There are three states: IDLE, RAMP and STOP.
- Reset values: state IDLE; `tgt`=0; `duty`=0; `busy`=0; `at_target`=0; `tgt_ready`=0.
- `tgt_ready` is registered. Its next-state value is 1 unless the next state is STOP or `rst` is high. It is therefore 1 from the second cycle after `rst` falls.
- **IDLE**, on acceptance:
  - `tgt` <= `tgt_duty`.
  - If `tgt_duty` != `duty`, go to RAMP.
  - Otherwise stay in IDLE, with no `at_target` pulse.
- **RAMP**, on acceptance: `tgt` is replaced (retarget) and the state stays RAMP. Ramping continues from the current `duty`.
- **RAMP**, on each `period_end`, using the `tgt` value held *before* any same-cycle acceptance:
  - Compute `diff` = `tgt` − `duty` as an unsigned WIDTH+1-bit difference.
  - If `step`==0 or |`diff`| <= `step`: `duty` <= `tgt`, next state IDLE, `at_target`=1 on the following cycle.
  - Else if `tgt` > `duty`: `duty` <= `duty` + `step`.
  - Else: `duty` <= `duty` − `step`.
  - Duty cannot overflow or underflow, because a step is taken only when |`diff`| > `step`.
- **Same-cycle acceptance and `period_end`:** the step uses the old `tgt`. The new target governs from the next `period_end`. If the step lands exactly on the old target, go to IDLE and pulse `at_target`. Then, if the new `tgt` differs from the resulting `duty`, re-enter RAMP on the next cycle.
- **`step` sampling:** `step` is sampled on every `period_end` and may change between periods.
- **STOP** (entered from any state):
  - When `estop`=1 at an edge: next cycle `duty`=0, `tgt`=0, state STOP, `busy`=0, `tgt_ready`=0.
  - `estop` takes priority over acceptance and over `period_end`.
  - STOP ignores `tgt_valid` and `period_end`.
  - When `estop`=0 in STOP: next state IDLE with `duty`=0, and `tgt_ready`=1 on that same cycle.
- **`rst` mid-ramp:** returns all outputs to their reset values on the next edge. No partial step is applied.

## Timing
- **`duty` update:** `duty` changes only on the edge where `period_end`=1, so the new value applies from counter value 0 of the next period. The only exception is STOP entry, which is immediate.
- **Handshake latency:**
  - Acceptance at edge N gives `busy`=1 from N+1.
  - The first duty change happens at the first `period_end` edge after N.
- **Ramp duration:** ceil(|`tgt` − `duty`| / `step`) periods.
  - `at_target` is high on the cycle after the final `period_end` edge.
  - `busy` falls on the same edge that raises `at_target`.
- **`estop` latency:** `estop` asserted before edge N gives `duty`=0 after edge N, i.e. 1-cycle latency.
- **Clock domain:** all inputs are assumed synchronous to `clk`.

## Test plan
- **Reset, then ramp up:** reset, release, `step`=100, accept `tgt_duty`=350.
  - Expect `duty` 100, 200, 300, 350 on four successive `period_end` edges.
  - Expect `at_target` pulse after the 4th edge, and `busy` high from acceptance until then.
- **Ramp down, jump mode and no-op target:**
  - From `duty`=350 with `step`=100, accept `tgt_duty`=0: expect 250, 150, 50, 0.
  - Then with `step`=0, accept 1023: expect `duty`=1023 at the first `period_end`.
  - Then accept 1023 again: expect no RAMP and no `at_target` pulse.
- **Retarget mid-ramp:** ramp 0→800 with `step`=200. After `duty`=400, accept 100.
  - Expect 200, then 100, then an `at_target` pulse.
  - `duty` must not change between `period_end` pulses.
- **Acceptance coinciding with `period_end`:** at `duty`=300, old `tgt`=400, `step`=100, accept 50 on the same edge as `period_end`.
  - Expect `duty`=400, an `at_target` pulse, then RAMP down: 300, 200, 100, 50.
- **Emergency stop mid-ramp:** `duty`=600, `estop` high for 5 cycles with `tgt_valid` held high.
  - Expect `duty`=0 one cycle later, `tgt_ready`=0, and no acceptance.
  - After `estop` falls, expect `tgt_ready`=1 next cycle and `duty` staying 0 until a new target is accepted.
- **Reset mid-ramp:** assert `rst` for 1 cycle during RAMP at `duty`=500.
  - Expect `duty`=0, `busy`=0, `tgt_ready`=0, then `tgt_ready`=1 two cycles after release.
